// File: rtl/lce_link_pkg.sv
// Shared types and defaults for the board-to-board lce link monitor.
package lce_link_pkg;

  typedef enum logic [1:0] {
    LINK_DOWN    = 2'd0,
    LINK_ACQUIRE = 2'd1,
    LINK_LOCKED  = 2'd2,
    LINK_HOLD    = 2'd3
  } link_state_e;

  localparam logic [7:0]  LCE_FLOAT_EXP_INF   = 8'hFF;
  localparam logic [31:0] LCE_MIN_DEF         = 32'h3F00_0000;
  localparam logic [31:0] LCE_MAX_DEF         = 32'h3FC0_0000;
  localparam logic [31:0] LCE_DEFAULT_DEF     = 32'h3F80_0000;
  localparam int unsigned ACQ_FRAMES_DEF      = 32'd4;
  localparam int unsigned HOLD_CYC_DEF        = 32'd3;
  localparam int unsigned TIMEOUT_CYC_DEF     = 32'd64;

  // Positive, finite and inside [lo, hi]; positive floats order like unsigned ints.
  function automatic logic lce_frame_good(input logic [31:0] word,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (word[31] == 1'b0) && (word[30:23] != LCE_FLOAT_EXP_INF) &&
           (word >= lo) && (word <= hi);
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Toggle-to-pulse crossing: 2-flop synchroniser, edge reference, one pulse per toggle.
module toggle_sync (
  input  logic sim_clk,
  input  logic reset_global,
  input  logic toggle,
  output logic frame_stb
);

  logic       sync1_r;
  logic       sync2_r;
  logic       ref_r;
  logic [1:0] prime_r;

  // Synchroniser chain; strobes stay masked until the chain holds a real sample of the input.
  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      ref_r   <= 1'b0;
      prime_r <= 2'd0;
    end else begin
      sync1_r <= toggle;
      sync2_r <= sync1_r;
      ref_r   <= sync2_r;
      if (prime_r != 2'd3) begin
        prime_r <= prime_r + 2'd1;
      end
    end
  end

  assign frame_stb = (prime_r == 2'd3) && (sync2_r ^ ref_r);

endmodule

// File: rtl/lce_link_monitor.sv
// Validates SPI lce frames and runs the link FSM feeding the spindle.
// Define LCE_ERR_CNT_EN to build the error counters; otherwise they read zero.
module lce_link_monitor
  import lce_link_pkg::*;
#(
  parameter logic [31:0] LCE_MIN     = LCE_MIN_DEF,
  parameter logic [31:0] LCE_MAX     = LCE_MAX_DEF,
  parameter logic [31:0] LCE_DEFAULT = LCE_DEFAULT_DEF,
  parameter int unsigned ACQ_FRAMES  = ACQ_FRAMES_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        sim_clk,
  input  logic        reset_global,
  input  logic [31:0] rx_word,
  input  logic        rx_toggle,
  input  logic        clear_err,
  output logic [31:0] lce_out,
  output logic        lce_valid,
  output logic [1:0]  link_state,
  output logic        frame_stb,
  output logic [15:0] err_range_cnt,
  output logic [15:0] err_drop_cnt
);

  localparam logic [3:0] ACQ_C     = 4'(ACQ_FRAMES);
  localparam logic [7:0] HOLD_C    = 8'(HOLD_CYC);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYC);

  logic [31:0] rx_q_r;
  logic        frame_pend_r;
  logic [7:0]  gap_r;
  logic [3:0]  good_cnt_r, good_cnt_nxt_s;
  link_state_e state_r, state_nxt_s;
  logic [31:0] lce_r, lce_nxt_s;
  logic        valid_r;
  logic        good_s, gap_live_s, range_inc_s, drop_inc_s;

  toggle_sync u_toggle_sync (
    .sim_clk      (sim_clk),
    .reset_global (reset_global),
    .toggle       (rx_toggle),
    .frame_stb    (frame_stb)
  );

  // Frame capture and inter-frame gap counter.
  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      rx_q_r       <= 32'd0;
      frame_pend_r <= 1'b0;
      gap_r        <= 8'd0;
    end else begin
      frame_pend_r <= frame_stb;
      if (frame_stb) begin
        rx_q_r <= rx_word;
        gap_r  <= 8'd0;
      end else if (gap_r != TIMEOUT_C) begin
        gap_r <= gap_r + 8'd1;
      end
    end
  end

  assign good_s      = lce_frame_good(rx_q_r, LCE_MIN, LCE_MAX);
  assign range_inc_s = frame_pend_r && !good_s;
  // A frame in flight outranks any gap threshold reached on the same edge.
  assign gap_live_s  = !frame_stb && !frame_pend_r;

  // Link FSM next-state, lce selection and drop event.
  always_comb begin
    state_nxt_s    = state_r;
    good_cnt_nxt_s = good_cnt_r;
    lce_nxt_s      = lce_r;
    drop_inc_s     = 1'b0;
    case (state_r)
      LINK_DOWN: begin
        if (frame_pend_r && good_s) begin
          if (ACQ_C == 4'd1) begin
            state_nxt_s    = LINK_LOCKED;
            good_cnt_nxt_s = 4'd0;
            lce_nxt_s      = rx_q_r;
          end else begin
            state_nxt_s    = LINK_ACQUIRE;
            good_cnt_nxt_s = 4'd1;
          end
        end else begin
          lce_nxt_s = LCE_DEFAULT;
        end
      end
      LINK_ACQUIRE: begin
        if (frame_pend_r && good_s) begin
          if ((good_cnt_r + 4'd1) == ACQ_C) begin
            state_nxt_s    = LINK_LOCKED;
            good_cnt_nxt_s = 4'd0;
            lce_nxt_s      = rx_q_r;
          end else begin
            good_cnt_nxt_s = good_cnt_r + 4'd1;
          end
        end else if (frame_pend_r || (gap_live_s && (gap_r == TIMEOUT_C))) begin
          state_nxt_s    = LINK_DOWN;
          good_cnt_nxt_s = 4'd0;
          lce_nxt_s      = LCE_DEFAULT;
        end else begin
          good_cnt_nxt_s = good_cnt_r;
        end
      end
      LINK_LOCKED: begin
        if (frame_pend_r && good_s) begin
          lce_nxt_s = rx_q_r;
        end else if (gap_live_s && (gap_r > HOLD_C)) begin
          state_nxt_s = LINK_HOLD;
          drop_inc_s  = 1'b1;
        end else begin
          lce_nxt_s = lce_r;
        end
      end
      LINK_HOLD: begin
        if (frame_pend_r && good_s) begin
          state_nxt_s = LINK_LOCKED;
          lce_nxt_s   = rx_q_r;
        end else if (gap_live_s && (gap_r == TIMEOUT_C)) begin
          state_nxt_s = LINK_DOWN;
          lce_nxt_s   = LCE_DEFAULT;
        end else begin
          lce_nxt_s = lce_r;
        end
      end
      default: begin
        state_nxt_s    = LINK_DOWN;
        good_cnt_nxt_s = 4'd0;
        lce_nxt_s      = LCE_DEFAULT;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      state_r    <= LINK_DOWN;
      good_cnt_r <= 4'd0;
      lce_r      <= LCE_DEFAULT;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
      lce_r      <= lce_nxt_s;
      valid_r    <= (state_nxt_s == LINK_LOCKED) || (state_nxt_s == LINK_HOLD);
    end
  end

  assign lce_out    = lce_r;
  assign lce_valid  = valid_r;
  assign link_state = state_r;

`ifdef LCE_ERR_CNT_EN
  logic [15:0] err_range_r;
  logic [15:0] err_drop_r;

  // Saturating error counters; a clear outranks a same-cycle increment.
  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      err_range_r <= 16'd0;
      err_drop_r  <= 16'd0;
    end else if (clear_err) begin
      err_range_r <= 16'd0;
      err_drop_r  <= 16'd0;
    end else begin
      if (range_inc_s && (err_range_r != 16'hFFFF)) begin
        err_range_r <= err_range_r + 16'd1;
      end
      if (drop_inc_s && (err_drop_r != 16'hFFFF)) begin
        err_drop_r <= err_drop_r + 16'd1;
      end
    end
  end

  assign err_range_cnt = err_range_r;
  assign err_drop_cnt  = err_drop_r;
`else
  logic cnt_unused_s;
  assign cnt_unused_s  = clear_err ^ range_inc_s ^ drop_inc_s;
  assign err_range_cnt = 16'd0;
  assign err_drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_lce_link_monitor.sv
// Self-checking bench for lce_link_monitor: directed table, corner sequences, random frames vs model.
module tb_lce_link_monitor;

  localparam logic [31:0] L_MIN = 32'h3F00_0000;
  localparam logic [31:0] L_MAX = 32'h3FC0_0000;
  localparam logic [31:0] L_DEF = 32'h3F80_0000;
  localparam logic [31:0] G11   = 32'h3F8C_CCCD;

  logic        sim_clk = 1'b0;
  logic        reset_global;
  logic [31:0] rx_word;
  logic        rx_toggle;
  logic        clear_err;
  logic [31:0] lce_out;
  logic        lce_valid;
  logic [1:0]  link_state;
  logic        frame_stb;
  logic [15:0] err_range_cnt;
  logic [15:0] err_drop_cnt;

  lce_link_monitor dut (
    .sim_clk       (sim_clk),
    .reset_global  (reset_global),
    .rx_word       (rx_word),
    .rx_toggle     (rx_toggle),
    .clear_err     (clear_err),
    .lce_out       (lce_out),
    .lce_valid     (lce_valid),
    .link_state    (link_state),
    .frame_stb     (frame_stb),
    .err_range_cnt (err_range_cnt),
    .err_drop_cnt  (err_drop_cnt)
  );

  always #5 sim_clk = ~sim_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: edge index since reset release, toggle edge, capture edge.
  int          t;
  int          tk;
  int          cap;
  logic [31:0] tk_word;
  logic [31:0] cap_word;
  int          m_state;
  int          m_good;
  int          m_range;
  int          m_drop;
  logic [31:0] m_lce;

  function automatic int en(input int v);
`ifdef LCE_ERR_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic bit spec_good(input logic [31:0] w);
    return (w[31] == 1'b0) && (w[30:23] != 8'hFF) && (w >= L_MIN) && (w <= L_MAX);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Advance the model across one clock edge.
  task automatic model_step(input bit clr);
    int g;
    bit stb_edge;
    bit eval_edge;
    g = t - 1 - cap;
    if (g > 64) g = 64;
    stb_edge  = (t == tk + 3);
    eval_edge = (t == tk + 4);
    if (stb_edge) begin
      cap      = t;
      cap_word = tk_word;
    end
    if (eval_edge) begin
      if (!spec_good(cap_word)) begin
        if (m_range < 65535) m_range++;
        if (m_state == 1) begin
          m_state = 0;
          m_good  = 0;
        end
      end else begin
        case (m_state)
          0: begin m_state = 1; m_good = 1; end
          1: begin
            m_good++;
            if (m_good == 4) begin m_state = 2; m_lce = cap_word; end
          end
          default: begin m_state = 2; m_lce = cap_word; end
        endcase
      end
    end else if (!stb_edge) begin
      if (m_state == 2 && g > 3) begin
        m_state = 3;
        if (m_drop < 65535) m_drop++;
      end else if (m_state == 1 && g == 64) begin
        m_state = 0;
        m_good  = 0;
      end else if (m_state == 3 && g == 64) begin
        m_state = 0;
        m_lce   = L_DEF;
      end
    end
    if (clr) begin
      m_range = 0;
      m_drop  = 0;
    end
  endtask

  task automatic check_cycle();
    chk("frame_stb", 32'(frame_stb), 32'(t == tk + 2));
    chk("link_state", 32'(link_state), 32'(m_state));
    chk("lce_out", lce_out, m_lce);
    chk("lce_valid", 32'(lce_valid), 32'(m_state >= 2));
    chk("err_range_cnt", 32'(err_range_cnt), 32'(en(m_range)));
    chk("err_drop_cnt", 32'(err_drop_cnt), 32'(en(m_drop)));
  endtask

  task automatic tick();
    bit clr;
    clr = clear_err;
    @(posedge sim_clk);
    #1;
    t++;
    model_step(clr);
    check_cycle();
  endtask

  task automatic do_reset(input logic tog);
    reset_global = 1'b1;
    rx_toggle    = tog;
    clear_err    = 1'b0;
    #1;
    chk("reset lce_out", lce_out, L_DEF);
    chk("reset lce_valid", 32'(lce_valid), 32'd0);
    chk("reset link_state", 32'(link_state), 32'd0);
    chk("reset frame_stb", 32'(frame_stb), 32'd0);
    chk("reset err_range", 32'(err_range_cnt), 32'd0);
    chk("reset err_drop", 32'(err_drop_cnt), 32'd0);
    @(posedge sim_clk);
    #1;
    reset_global = 1'b0;
    t = 0; tk = -1000; cap = 0;
    m_state = 0; m_lce = L_DEF; m_good = 0; m_range = 0; m_drop = 0;
    repeat (4) tick();
  endtask

  task automatic send(input logic [31:0] w, input int n);
    rx_word   = w;
    rx_toggle = ~rx_toggle;
    tk        = t;
    tk_word   = w;
    repeat (n) tick();
  endtask

  typedef struct {
    bit          tog;
    logic [31:0] word;
    int          n;
    int          st;
    logic [31:0] lce;
    bit          vld;
    int          rng;
    int          drp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int c;
    logic [31:0] bnd [4];
    rx_word = L_DEF;
    rx_toggle = 1'b0;
    clear_err = 1'b0;
    reset_global = 1'b1;
    t = 0; tk = -1000; cap = 0;

    // Expected values derived by hand from the link rules (ACQ_FRAMES=4, HOLD 3, TIMEOUT 64).
    tbl.push_back('{1'b1, G11,            4, 1, L_DEF, 1'b0, 0, 0});
    tbl.push_back('{1'b1, G11,            4, 1, L_DEF, 1'b0, 0, 0});
    tbl.push_back('{1'b1, G11,            4, 1, L_DEF, 1'b0, 0, 0});
    tbl.push_back('{1'b1, G11,            4, 2, G11,   1'b1, 0, 0});
    tbl.push_back('{1'b1, 32'h7FC0_0000,  4, 2, G11,   1'b1, 1, 0});
    tbl.push_back('{1'b1, 32'hBF80_0000,  4, 2, G11,   1'b1, 2, 0});
    tbl.push_back('{1'b0, 32'h0000_0000,  3, 2, G11,   1'b1, 2, 0});
    tbl.push_back('{1'b0, 32'h0000_0000,  1, 3, G11,   1'b1, 2, 1});
    tbl.push_back('{1'b0, 32'h0000_0000, 59, 3, G11,   1'b1, 2, 1});
    tbl.push_back('{1'b0, 32'h0000_0000,  1, 0, L_DEF, 1'b0, 2, 1});
    tbl.push_back('{1'b1, G11,            4, 1, L_DEF, 1'b0, 2, 1});
    tbl.push_back('{1'b1, G11,            4, 1, L_DEF, 1'b0, 2, 1});
    tbl.push_back('{1'b1, 32'h4000_0000,  4, 0, L_DEF, 1'b0, 3, 1});
    tbl.push_back('{1'b1, L_MIN,          4, 1, L_DEF, 1'b0, 3, 1});
    tbl.push_back('{1'b1, L_MIN,          4, 1, L_DEF, 1'b0, 3, 1});
    tbl.push_back('{1'b1, L_MIN,          4, 1, L_DEF, 1'b0, 3, 1});
    tbl.push_back('{1'b1, L_MAX,          4, 2, L_MAX, 1'b1, 3, 1});
    tbl.push_back('{1'b1, 32'h3FC0_0001,  4, 2, L_MAX, 1'b1, 4, 1});
    tbl.push_back('{1'b1, 32'h3EFF_FFFF,  4, 2, L_MAX, 1'b1, 5, 1});
    tbl.push_back('{1'b1, 32'h7F80_0000,  5, 2, L_MAX, 1'b1, 6, 1});

    do_reset(1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].tog) send(tbl[i].word, tbl[i].n);
      else repeat (tbl[i].n) tick();
      chk($sformatf("row%0d state", i), 32'(link_state), 32'(tbl[i].st));
      chk($sformatf("row%0d lce", i), lce_out, tbl[i].lce);
      chk($sformatf("row%0d valid", i), 32'(lce_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d range", i), 32'(err_range_cnt), 32'(en(tbl[i].rng)));
      chk($sformatf("row%0d drop", i), 32'(err_drop_cnt), 32'(en(tbl[i].drp)));
    end

    // Clear in the same cycle as a bad frame's count.
    rx_word = 32'hFFFF_FFFF;
    rx_toggle = ~rx_toggle;
    tk = t;
    tk_word = rx_word;
    repeat (3) tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clear_vs_incr range", 32'(err_range_cnt), 32'd0);
    chk("clear_vs_incr drop", 32'(err_drop_cnt), 32'd0);
    chk("clear_vs_incr state", 32'(link_state), 32'd2);

    // Reset mid-frame: the in-flight frame is discarded.
    send(G11, 2);
    do_reset(rx_toggle);
    repeat (6) tick();
    chk("midreset state", 32'(link_state), 32'd0);

    // Stale toggle level through reset release gives no frame; next toggle gives one.
    rx_word = G11;
    do_reset(1'b1);
    c = 0;
    repeat (8) begin tick(); c += int'(frame_stb); end
    chk("stale no strobe", 32'(c), 32'd0);
    rx_toggle = 1'b0;
    tk = t;
    tk_word = rx_word;
    c = 0;
    repeat (8) begin tick(); c += int'(frame_stb); end
    chk("first toggle one strobe", 32'(c), 32'd1);
    chk("first toggle acquire", 32'(link_state), 32'd1);

    // Randomised frames and gaps against the model.
    bnd[0] = L_MIN; bnd[1] = L_MAX; bnd[2] = L_MIN - 32'd1; bnd[3] = L_MAX + 32'd1;
    for (int i = 0; i < 250; i++) begin
      int sel;
      int n;
      logic [31:0] w;
      sel = $urandom_range(0, 9);
      if (sel < 6) w = L_MIN + ($urandom % (L_MAX - L_MIN + 32'd1));
      else if (sel == 6) w = bnd[$urandom_range(0, 3)];
      else w = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 7) n = $urandom_range(4, 5);
      else if (sel < 9) n = $urandom_range(6, 12);
      else n = $urandom_range(60, 70);
      clear_err = ($urandom_range(0, 19) == 0);
      send(w, n);
      clear_err = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
